// File: rtl/led_disp_pkg.sv
// Shared types and helpers for the LED display arbiter.
package led_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OWN  = 2'd2
  } state_e;

  localparam int N_SRC     = 3;
  localparam int SRC_POS   = 0;
  localparam int SRC_SPI   = 1;
  localparam int SRC_FAULT = 2;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Highest-index requester wins (fault > SPI > position).
  function automatic logic [N_SRC-1:0] prio_pick(input logic [N_SRC-1:0] req);
    logic [N_SRC-1:0] pick;
    pick = '0;
    if (req[SRC_FAULT])    pick[SRC_FAULT] = 1'b1;
    else if (req[SRC_SPI]) pick[SRC_SPI]   = 1'b1;
    else if (req[SRC_POS]) pick[SRC_POS]   = 1'b1;
    return pick;
  endfunction

  // Sources strictly above the one-hot owner.
  function automatic logic [N_SRC-1:0] higher_mask(input logic [N_SRC-1:0] owner);
    logic [N_SRC-1:0] m;
    logic seen;
    m    = '0;
    seen = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      m[i] = seen;
      if (owner[i]) seen = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/led_display_arbiter_blink.sv
// Free-running blink phase generator; restart forces a fresh visible phase.
module led_blink_gen #(
  parameter int unsigned BLINK_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic restart_i,
  output logic phase_d_o
);
  localparam int CW = $clog2(BLINK_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (run_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Next-phase output lets the parent register led_on in the same edge as grant.
  assign phase_d_o = phase_d;

endmodule

// File: rtl/led_display_arbiter.sv
// Priority arbiter with minimum hold time sharing the 16-LED array between
// position, SPI and fault pattern sources; feeds the LED PWM dimmer.
//   state | meaning
//   IDLE  | no owner, LEDs dark
//   HOLD  | owner granted, minimum display time running
//   OWN   | hold expired, owner keeps display while requesting
module led_display_arbiter
  import led_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100000000,
  parameter int unsigned HOLD_MS       = 200,
  parameter int unsigned BLINK_HALF_MS = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     src_req,
  input  logic [16*N_SRC-1:0]  src_pattern,
  input  logic [N_SRC-1:0]     src_blink,
  output logic [15:0]          led_on,
  output logic [N_SRC-1:0]     grant,
  output logic                 busy
);
  localparam int unsigned HOLD_CYC  = ms_to_cycles(CLK_HZ, HOLD_MS);
  localparam int unsigned BLINK_CYC = ms_to_cycles(CLK_HZ, BLINK_HALF_MS);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("led_display_arbiter: hold time rounds to zero cycles");
  end
  if (BLINK_CYC < 1) begin : g_bad_blink
    $error("led_display_arbiter: blink half-period rounds to zero cycles");
  end

  state_e           state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [15:0]      latched_q, latched_d;
  logic [15:0]      led_q, led_d;
  logic             busy_q;

  logic             owner_req, hi_req, do_arb, new_req, new_blink, phase_d;
  logic [15:0]      new_pat;

  assign owner_req = |(src_req & grant_q);
  assign hi_req    = |(src_req & higher_mask(grant_q));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    do_arb  = 1'b0;
    unique case (state_q)
      IDLE: do_arb = |src_req;
      HOLD: begin
        if (hi_req)             do_arb = 1'b1;
        else if (hold_q == '0) begin
          if (owner_req) state_d = OWN;
          else           do_arb  = 1'b1;
        end else         hold_d  = hold_q - 1'b1;
      end
      OWN:  do_arb = hi_req || !owner_req;
      default: do_arb = 1'b1;
    endcase
    if (do_arb) begin
      grant_d = prio_pick(src_req);
      if (|grant_d) begin
        state_d = HOLD;
        hold_d  = HOLD_LOAD;
      end else begin
        state_d = IDLE;
        hold_d  = '0;
      end
    end
  end

  always_comb begin
    new_pat   = '0;
    new_req   = 1'b0;
    new_blink = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_d[i]) begin
        new_pat   = src_pattern[16*i +: 16];
        new_req   = src_req[i];
        new_blink = src_blink[i];
      end
    end
  end

  // Pattern freezes once the owner lets go, so a short pulse stays visible.
  always_comb begin
    latched_d = latched_q;
    if (grant_d == '0) latched_d = '0;
    else if (new_req)  latched_d = new_pat;
    led_d = latched_d & {16{phase_d | ~new_blink}};
  end

  led_blink_gen #(.BLINK_CYC(BLINK_CYC)) u_blink (
    .clk       (clk),
    .rst       (rst),
    .run_i     (|grant_q),
    .restart_i (grant_d != grant_q),
    .phase_d_o (phase_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      hold_q    <= '0;
      latched_q <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      hold_q    <= hold_d;
      latched_q <= latched_d;
      led_q     <= led_d;
      busy_q    <= |grant_d;
    end
  end

  assign led_on = led_q;
  assign grant  = grant_q;
  assign busy   = busy_q;

endmodule

// File: doc/led_display_arbiter.md
Name: led_display_arbiter

Overview:
- Shares the 16-LED array between three pattern sources: servo position bar, SPI activity and fault indicator.
- Picks one owner at a time using fixed priority with a minimum display (hold) time, so short requests stay visible.
- Applies optional blinking to the owner's pattern.
- Drives the led_on input of the LED PWM dimmer stage. Sits between the servo/SPI control logic and that PWM stage.

Parameters:
- CLK_HZ, 100000000, clk frequency in Hz.
- HOLD_MS, 200, minimum time a granted source owns the display, in ms.
- BLINK_HALF_MS, 250, blink on-phase and off-phase length, in ms.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- src_req  input  3  per-source display request; bit 2 = fault, bit 1 = SPI, bit 0 = servo position.
- src_pattern  input  48  three 16-bit LED patterns; source i occupies bits [16i+15:16i].
- src_blink  input  3  per-source blink enable, sampled live while the source owns the display.
- led_on  output  16  registered LED pattern sent to the PWM stage.
- grant  output  3  one-hot owner; 0 when idle.
- busy  output  1  high whenever grant != 0.

Behaviour:
- Constants: HOLD_CYC = CLK_HZ/1000*HOLD_MS; BLINK_CYC = CLK_HZ/1000*BLINK_HALF_MS.
  - Counters are $clog2(max+1) wide.
  - Both constants must be >= 1; enforce with an elaboration-time check.
- Reset: state IDLE, led_on=0, grant=0, busy=0, hold_cnt=0, blink_cnt=0, blink_phase=1, latched pattern=0.
- Priority: fault > SPI > position.
- All outputs are registered. A request sampled at edge n appears on grant and led_on after edge n+1 (one-cycle latency).
- FSM states: IDLE, HOLD, OWN.
  - IDLE: if any src_req, grant the highest-priority requester, load hold_cnt=HOLD_CYC-1, go to HOLD. Otherwise led_on=0.
  - HOLD: hold_cnt decrements each cycle.
    - A request from a strictly higher-priority source preempts at once: new grant, hold_cnt reloaded, stay in HOLD.
    - Lower or equal priority requests are ignored.
    - When hold_cnt==0: go to OWN if the owner's req is high, otherwise re-arbitrate.
  - OWN: held while the owner's req is high.
    - A higher-priority request preempts, same as in HOLD.
    - When the owner's req drops, re-arbitrate.
  - Re-arbitrate: grant the highest current requester and go to HOLD with hold_cnt reloaded. If no requester, go to IDLE.
  - Re-arbitration happens in the same cycle, with no idle gap.
- Pattern:
  - While the owner's req is high, the latched pattern tracks src_pattern[owner] every cycle.
  - After the owner's req drops during HOLD, the last latched pattern is shown until hold expires.
- Blink:
  - blink_cnt runs freely while busy and toggles blink_phase every BLINK_CYC cycles.
  - On every grant change, blink_cnt=0 and blink_phase=1, so the first phase is visible.
  - led_on = latched & {16{blink_phase | ~src_blink[owner]}}.
- Simultaneous events:
  - Hold expiry and a higher-priority request in the same cycle: preemption.
  - Hold expiry and owner release in the same cycle: re-arbitrate.
  - Two new requesters at once: priority decides.
- rst asserted mid-operation returns every register to its reset value at the next edge, whatever the current state.

Decomposition:
- Package led_disp_pkg holds:
  - state enum (IDLE, HOLD, OWN);
  - source index localparams SRC_POS=0, SRC_SPI=1, SRC_FAULT=2;
  - N_SRC=3;
  - function ms_to_cycles(clk_hz, ms).
- One sub-module: led_blink_gen (blink counter and phase, with a restart input). The FSM and pattern latch stay in the top module.

Test Plan (CLK_HZ=1000, HOLD_MS=4, BLINK_HALF_MS=2, so HOLD_CYC=4 and BLINK_CYC=2):
1. Reset, then src_req=3'b001 with pattern0=16'h00FF held. One cycle later: grant=001, led_on=00FF, busy=1. Drop req after 10 cycles: grant=0 and led_on=0 one cycle later.
2. src_req=010 pulsed for 1 cycle with pattern1=16'hA5A5. led_on=A5A5 for exactly 4 cycles, then 0 (pulse stretch).
3. Position owns the display with pattern0=00FF. Raise src_req[2] with pattern2=FFFF. The next cycle shows grant=100, led_on=FFFF. Then drop the fault req while position is still requesting: after the 4-cycle hold, grant=001, led_on=00FF.
4. SPI in HOLD, position requests: no preemption. SPI releases at hold expiry in the same cycle: grant moves to 001 with no idle cycle.
5. Fault owns the display with src_blink=100 and pattern2=F00F. led_on sequence is F00F,F00F,0000,0000,F00F, repeating; the first phase is on.
6. Assert rst mid-HOLD with grant=010: the next cycle shows grant=0, led_on=0, busy=0. After rst is released with src_req=000, the block stays IDLE.
